alu_seq_unit: RTL and testbench

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

---
 rtl/alu_seq_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_unit
// Description : Sequential ALU that completes add/sub/and/or/slt in one cycle,
//               shifts one bit per cycle, and does an optional shift-add
//               multiply. Macro ALU_SEQ_MUL_EN enables the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       aluop,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             link_rt,
    output logic             reg31_rt
);

    localparam int             CW      = SHW + 1;
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] ST_MUL   = 2'd2;
`endif
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SLT = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] OP_MUL = 3'd7;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             shl_q, shl_d;
    logic             link_pend_q, link_pend_d;
    logic             r31_pend_q, r31_pend_d;
    logic             link_q, link_d;
    logic             r31_q, r31_d;
`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] w_mul_sum;
`endif

    logic [2:0]       w_op;
    logic             w_is_link;
    logic             w_is_r31;
    logic [WIDTH-1:0] w_imm_res;
    logic [WIDTH-1:0] w_shift_step;
    logic [SHW-1:0]   w_shamt;

    assign w_shamt = b[SHW-1:0];

    // Operation decode; unlisted R-type codes fall back to add.
    always_comb begin
        w_op = OP_ADD;
        case (aluop)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b11: w_op = OP_OR;
            default: begin
                case (funct)
                    4'b0001: w_op = OP_SLL;
                    4'b0010: w_op = OP_SRL;
                    4'b0110: w_op = OP_SUB;
                    4'b0100: w_op = OP_AND;
                    4'b0101: w_op = OP_OR;
                    4'b1010: w_op = OP_SLT;
`ifdef ALU_SEQ_MUL_EN
                    4'b1100: w_op = OP_MUL;
`endif
                    default: w_op = OP_ADD;
                endcase
            end
        endcase
        w_is_link = (aluop == 2'b10) && ((funct == 4'b0101) || (funct == 4'b1001));
        w_is_r31  = (aluop == 2'b10) && (funct == 4'b0101);
    end

    // Single-cycle results; a shift by zero passes operand A through.
    always_comb begin
        w_imm_res = a;
        case (w_op)
            OP_ADD:  w_imm_res = a + b;
            OP_SUB:  w_imm_res = a - b;
            OP_AND:  w_imm_res = a & b;
            OP_OR:   w_imm_res = a | b;
            OP_SLT:  w_imm_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: w_imm_res = a;
        endcase
    end

    assign w_shift_step = shl_q ? (acc_q << 1) : (acc_q >> 1);
`ifdef ALU_SEQ_MUL_EN
    assign w_mul_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        shl_d       = shl_q;
        link_pend_d = link_pend_q;
        r31_pend_d  = r31_pend_q;
        link_d      = link_q;
        r31_d       = r31_q;
`ifdef ALU_SEQ_MUL_EN
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    link_pend_d = w_is_link;
                    r31_pend_d  = w_is_r31;
                    if (((w_op == OP_SLL) || (w_op == OP_SRL)) && (w_shamt != '0)) begin
                        state_d = ST_SHIFT;
                        acc_d   = a;
                        cnt_d   = {1'b0, w_shamt};
                        shl_d   = (w_op == OP_SLL);
`ifdef ALU_SEQ_MUL_EN
                    end else if (w_op == OP_MUL) begin
                        state_d  = ST_MUL;
                        acc_d    = '0;
                        mcand_d  = a;
                        mplier_d = b;
                        cnt_d    = CW'(WIDTH);
`endif
                    end else begin
                        state_d  = ST_DONE;
                        result_d = w_imm_res;
                        link_d   = w_is_link;
                        r31_d    = w_is_r31;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = w_shift_step;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = ST_DONE;
                    result_d = w_shift_step;
                    link_d   = link_pend_q;
                    r31_d    = r31_pend_q;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                acc_d    = w_mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d  = ST_DONE;
                    result_d = w_mul_sum;
                    link_d   = link_pend_q;
                    r31_d    = r31_pend_q;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            shl_q       <= 1'b0;
            link_pend_q <= 1'b0;
            r31_pend_q  <= 1'b0;
            link_q      <= 1'b0;
            r31_q       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand_q     <= '0;
            mplier_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            shl_q       <= shl_d;
            link_pend_q <= link_pend_d;
            r31_pend_q  <= r31_pend_d;
            link_q      <= link_d;
            r31_q       <= r31_d;
`ifdef ALU_SEQ_MUL_EN
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
`endif
        end
    end

    assign result   = result_q;
    assign zero     = (result_q == '0);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign link_rt  = link_q;
    assign reg31_rt = r31_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_unit
// Description : Randomized self-checking bench for alu_seq_unit against a
//               behavioural model; honours ALU_SEQ_MUL_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   aluop = 2'b00;
    logic [3:0]   funct = 4'b0000;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] result;
    logic         zero, busy, done, link_rt, reg31_rt;

    int errors = 0;
    int checks = 0;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .aluop(aluop), .funct(funct),
        .a(a), .b(b), .result(result), .zero(zero), .busy(busy), .done(done),
        .link_rt(link_rt), .reg31_rt(reg31_rt)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_res(input logic [1:0] op, input logic [3:0] f,
                                               input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        if (op == 2'b00) return x + y;
        if (op == 2'b01) return x - y;
        if (op == 2'b11) return x | y;
        case (f)
            4'd1:  return x << y[4:0];
            4'd2:  return x >> y[4:0];
            4'd6:  return x - y;
            4'd4:  return x & y;
            4'd5:  return x | y;
            4'd10: return ($signed(x) < $signed(y)) ? 1 : 0;
`ifdef ALU_SEQ_MUL_EN
            4'd12: return prod[W-1:0];
`endif
            default: return x + y;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [3:0] f, input logic [W-1:0] y);
        if (op == 2'b10 && (f == 4'd1 || f == 4'd2)) return int'(y[4:0]) + 1;
`ifdef ALU_SEQ_MUL_EN
        if (op == 2'b10 && f == 4'd12) return W + 1;
`endif
        return 1;
    endfunction

    // Issue one request, scramble the inputs after acceptance, and count
    // cycles until done (1 = done in the cycle after the accepting edge).
    task automatic run_op(input logic [1:0] op, input logic [3:0] f,
                          input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
        @(negedge clk);
        start = 1'b1; aluop = op; funct = f; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom; aluop = 2'($urandom); funct = 4'($urandom);
        lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({result, zero, busy, done, link_rt, reg31_rt} !== {32'h0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL reset_state: got res=%h z=%b busy=%b done=%b lk=%b r31=%b expected res=0 z=1 others 0",
                     result, zero, busy, done, link_rt, reg31_rt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        int lat;
        run_op(2'b00, 4'd0, 32'd5, 32'd7, lat);
        checks++;
        if ({lat, result, zero, link_rt} !== {32'd1, 32'd12, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL add_5_7: got lat=%0d res=%h z=%b lk=%b expected lat=1 res=c z=0 lk=0", lat, result, zero, link_rt);
        end
        run_op(2'b10, 4'b1010, 32'hFFFF_FFFF, 32'd1, lat);
        checks++;
        if ({lat, result} !== {32'd1, 32'd1}) begin
            errors++;
            $display("FAIL slt_signed: got lat=%0d res=%h expected lat=1 res=1", lat, result);
        end
        run_op(2'b10, 4'b0110, 32'd9, 32'd9, lat);
        checks++;
        if ({result, zero} !== {32'd0, 1'b1}) begin
            errors++;
            $display("FAIL sub_zero: got res=%h z=%b expected res=0 z=1", result, zero);
        end
        run_op(2'b10, 4'b0101, 32'hF0, 32'h0F, lat);
        checks++;
        if ({result, link_rt, reg31_rt} !== {32'hFF, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL or_link: got res=%h lk=%b r31=%b expected res=ff lk=1 r31=1", result, link_rt, reg31_rt);
        end
        run_op(2'b10, 4'b1001, 32'h3, 32'h4, lat);
        checks++;
        if ({result, link_rt, reg31_rt} !== {32'h7, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL link_1001: got res=%h lk=%b r31=%b expected res=7 lk=1 r31=0", result, link_rt, reg31_rt);
        end
        run_op(2'b00, 4'b0101, 32'h1, 32'h1, lat);
        checks++;
        if ({link_rt, reg31_rt} !== 2'b00) begin
            errors++;
            $display("FAIL link_non_rtype: got lk=%b r31=%b expected 0 0", link_rt, reg31_rt);
        end
        run_op(2'b10, 4'b1100, 32'h10001, 32'h10001, lat);
        checks++;
        if ({lat, result} !== {model_lat(2'b10, 4'b1100, 32'h10001), model_res(2'b10, 4'b1100, 32'h10001, 32'h10001)}) begin
            errors++;
            $display("FAIL funct_1100: got lat=%0d res=%h expected lat=%0d res=%h", lat, result,
                     model_lat(2'b10, 4'b1100, 32'h10001), model_res(2'b10, 4'b1100, 32'h10001, 32'h10001));
        end
        run_op(2'b10, 4'b0001, 32'hABCD, 32'h20, lat);
        checks++;
        if ({lat, result} !== {32'd1, 32'hABCD}) begin
            errors++;
            $display("FAIL shift_amt_zero: got lat=%0d res=%h expected lat=1 res=abcd", lat, result);
        end
    endtask

    task automatic test_shift_long;
        int lat;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; aluop = 2'b10; funct = 4'b0010; a = 32'h8000_0000; b = 32'd31;
        @(negedge clk);
        aluop = 2'b00; a = 32'd1; b = 32'd1;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (lat == 3) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++;
        if ({lat, busy_cnt, result} !== {32'd32, 32'd31, 32'd1}) begin
            errors++;
            $display("FAIL srl_31: got lat=%0d busy_cycles=%0d res=%h expected lat=32 busy_cycles=31 res=1",
                     lat, busy_cnt, result);
        end
        @(negedge clk);
        checks++;
        if ({done, busy, result} !== {1'b0, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL start_while_busy: got done=%b busy=%b res=%h expected 0 0 1", done, busy, result);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        start = 1'b1; aluop = 2'b11; funct = 4'd0; a = 32'h1200; b = 32'h0034;
        @(negedge clk);
        aluop = 2'b00; a = 32'd100; b = 32'd200;
        checks++;
        if ({done, result} !== {1'b1, 32'h1234}) begin
            errors++;
            $display("FAIL or_aluop11: got done=%b res=%h expected 1 1234", done, result);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, busy, result} !== {1'b0, 1'b0, 32'h1234}) begin
            errors++;
            $display("FAIL start_in_done: got done=%b busy=%b res=%h expected 0 0 1234", done, busy, result);
        end
        repeat (3) begin
            a = $urandom; b = $urandom;
            @(negedge clk);
        end
        checks++;
        if ({done, result} !== {1'b0, 32'h1234}) begin
            errors++;
            $display("FAIL result_hold: got done=%b res=%h expected 0 1234", done, result);
        end
    endtask

    task automatic test_random;
        int lat;
        logic [1:0]   op;
        logic [3:0]   f;
        logic [W-1:0] x, y, exp_res;
        logic         exp_link;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom);
            f  = 4'($urandom);
            x  = $urandom;
            y  = $urandom;
            if ($urandom_range(0, 3) == 0) y[4:0] = 5'd0;
            exp_res  = model_res(op, f, x, y);
            exp_link = (op == 2'b10) && (f == 4'd5 || f == 4'd9);
            run_op(op, f, x, y, lat);
            checks++;
            if ({lat, result, zero, link_rt, reg31_rt} !==
                {model_lat(op, f, y), exp_res, exp_res == 0, exp_link, (op == 2'b10) && (f == 4'd5)}) begin
                errors++;
                $display("FAIL random[%0d] op=%b f=%h a=%h b=%h: got lat=%0d res=%h z=%b lk=%b r31=%b expected lat=%0d res=%h",
                         i, op, f, x, y, lat, result, zero, link_rt, reg31_rt, model_lat(op, f, y), exp_res);
            end
        end
    endtask

    task automatic abort_case(input logic [3:0] f, input int cyc);
        int lat;
        int pulses;
        run_op(2'b10, 4'b0101, 32'h55, 32'hAA00, lat);
        @(negedge clk);
        start = 1'b1; aluop = 2'b10; funct = f; a = 32'h1234_5678; b = 32'h0000_0314;
        @(negedge clk);
        start = 1'b0;
        repeat (cyc - 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({result, zero, busy, done, link_rt, reg31_rt} !== {32'h0, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL abort_f%h_outputs: got res=%h z=%b busy=%b done=%b lk=%b r31=%b expected res=0 z=1 others 0",
                     f, result, zero, busy, done, link_rt, reg31_rt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL abort_f%h_no_done: got %0d done pulses expected 0", f, pulses);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1; aluop = 2'b00; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({done, result} !== {1'b1, 32'd7}) begin
            errors++;
            $display("FAIL start_after_reset: got done=%b res=%h expected 1 7", done, result);
        end
    endtask

    task automatic test_reset_abort;
        abort_case(4'b0010, 10);
`ifdef ALU_SEQ_MUL_EN
        abort_case(4'b1100, 10);
`endif
    endtask

    initial begin
        test_reset;
        test_directed;
        test_shift_long;
        test_back_to_back;
        test_random;
        test_reset_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
